ram_req_ctrl: RTL and testbench

- Request-side controller that sits directly upstream of the single-port RAM block and drives its data_in/write_enb/read_enb/address pins.
- Accepts a valid/ready request stream (read or write) and issues at most one RAM access per cycle.
- Captures RAM data_out after the RAM read latency and returns read data on a valid/ready response stream through a small credit-protected response FIFO.

---
 rtl/ram_ctrl_pkg.sv | 26 ++
 rtl/ram_req_ctrl_if.sv | 33 +++
 rtl/ram_rsp_fifo.sv | 74 +++++++
 rtl/ram_req_ctrl.sv | 137 +++++++++++++
 tb/tb_ram_req_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared defaults, init-state encoding and request record for the RAM request controller.
// Revision: 1.0
`default_nettype none

package ram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RD_LATENCY = 1;
  localparam int DEF_RSP_DEPTH  = 2;

  typedef enum logic [0:0] {
    INIT_CLEAR = 1'b0,
    RUN        = 1'b1
  } init_state_e;

  // Request record at the default geometry.
  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/ram_req_ctrl_if.sv
// ram_req_ctrl_if: request and response valid/ready streams of the RAM request controller.
// Revision: 1.0
`default_nettype none

interface ram_req_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

`default_nettype wire

// File: rtl/ram_rsp_fifo.sv
// ram_rsp_fifo: first-word fall-through response FIFO with a registered head word.
// Revision: 1.0
`default_nettype none

module ram_rsp_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          pop_data,
  output logic [$clog2(RSP_DEPTH+1)-1:0] count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic                  pop_ok;
  logic                  head_from_push;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(RSP_DEPTH));
  assign pop_ok = pop && !empty;
  assign rd_nxt = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
  // The incoming word becomes the head when nothing older survives this edge.
  assign head_from_push = empty || (pop_ok && (count == CNT_W'(1)));

  always_comb begin
    count_nxt = count;
    if (push && !pop_ok) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop_ok) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pop_data only moves when a word remains, so an empty FIFO holds the last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) begin
        pop_data <= head_from_push ? push_data : mem[rd_nxt];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: issues request-stream accesses to a single-port RAM and returns read data in order.
// Optional RAM_INIT_CLEAR_EN zero-fills the RAM after reset. Revision: 1.0
`default_nettype none

module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_req_ctrl_if.slave         bus,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  write_enb,
  output logic                  read_enb,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy
);

  localparam int CREDIT_W = $clog2(RSP_DEPTH + 1);

  logic                  init_active;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  accept;
  logic                  accept_rd;
  logic                  pop;
  logic [CREDIT_W-1:0]   credits;
  logic [RD_LATENCY:0]   rd_pipe;
  logic [CREDIT_W-1:0]   fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

`ifdef RAM_INIT_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = INIT_CLEAR;
  localparam logic [0:0] ST_RUN   = RUN;

  logic [0:0] state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (clr_addr == '1) begin
        state <= ST_RUN;
      end
    end
  end

  assign init_active = (state == ST_CLEAR);
`else
  assign init_active = 1'b0;
  assign clr_addr    = '0;
`endif

  // Ready depends on registered state only; writes stall on zero credits too.
  assign bus.req_ready = !init_active && (credits != '0);
  assign accept        = bus.req_valid && bus.req_ready;
  assign accept_rd     = accept && !bus.req_write;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enb <= 1'b0;
      read_enb  <= 1'b0;
      address   <= '0;
      data_in   <= '0;
    end else if (init_active) begin
      write_enb <= 1'b1;
      read_enb  <= 1'b0;
      address   <= clr_addr;
      data_in   <= '0;
    end else if (accept) begin
      write_enb <= bus.req_write;
      read_enb  <= !bus.req_write;
      address   <= bus.req_addr;
      if (bus.req_write) begin
        data_in <= bus.req_wdata;
      end
    end else begin
      write_enb <= 1'b0;
      read_enb  <= 1'b0;
    end
  end

  // A credit covers a read from acceptance until its response is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= CREDIT_W'(RSP_DEPTH);
    end else if (accept_rd && !pop) begin
      credits <= credits - CREDIT_W'(1);
    end else if (!accept_rd && pop) begin
      credits <= credits + CREDIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RD_LATENCY-1:0], accept_rd};
    end
  end

  ram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pipe[RD_LATENCY]),
    .push_data (data_out),
    .pop       (pop),
    .pop_data  (bus.rsp_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign busy          = init_active || (|rd_pipe) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rd_pipe[RD_LATENCY] && fifo_full && !pop));
      assert (!(write_enb && read_enb));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: randomized and directed checks of ram_req_ctrl against a queue-based reference.
// Revision: 1.0
`default_nettype none

module tb_ram_req_ctrl;
  import ram_ctrl_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int RDL   = 1;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          write_enb;
  logic          read_enb;
  logic [AW-1:0] address;
  logic          busy;

  always #5 clk = ~clk;

  ram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_req_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (RDL),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .data_in   (data_in),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .address   (address),
    .data_out  (data_out),
    .busy      (busy)
  );

  // RAM: samples pins on the edge, data_out valid RDL edges later.
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] rp  [RDL];
  always @(posedge clk) begin
    if (write_enb) ram[address] <= data_in;
    rp[0] <= ram[address];
    for (int i = 1; i < RDL; i++) rp[i] <= rp[i-1];
  end
  assign data_out = rp[RDL-1];

  // Reference: memory image at acceptance time plus a queue of reads awaiting return.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pend[$];
  logic [DW-1:0] ref_mem [2**AW];
  int            idx = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  logic          obs_ready, obs_valid, obs_we, obs_re, obs_busy, hs;
  logic [DW-1:0] obs_rdata, obs_din;
  logic [AW-1:0] obs_addr;
  logic          exp_ready, exp_valid;
  logic [DW-1:0] exp_rdata;

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    #1;
    obs_ready = bus.req_ready;
    obs_valid = bus.rsp_valid;
    obs_rdata = bus.rsp_rdata;
    obs_we    = write_enb;
    obs_re    = read_enb;
    obs_addr  = address;
    obs_din   = data_in;
    obs_busy  = busy;
    exp_ready = (pend.size() < DEPTH);
    exp_valid = (pend.size() != 0) && (pend[0].due <= idx);
    exp_rdata = exp_valid ? pend[0].data : '0;
    hs = v && obs_ready;
    if (obs_valid && rr && pend.size() != 0) void'(pend.pop_front());
    if (hs) begin
      if (w) ref_mem[a] = d;
      else   pend.push_back('{due: idx + RDL + 2, data: ref_mem[a]});
    end
    idx++;
  endtask

  task automatic release_reset;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pend.delete();
`ifdef RAM_INIT_CLEAR_EN
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs_ready !== 1'b0 || obs_we !== 1'b1 || obs_addr !== AW'(k-1) || obs_din !== '0) begin
        n_fail++;
        $display("FAIL init_sweep k=%0d got ready=%b we=%b addr=%0d din=%h exp ready=0 we=1 addr=%0d din=00",
                 k, obs_ready, obs_we, obs_addr, obs_din, k-1);
      end
    end
    for (int a = 0; a < 2**AW; a++) ref_mem[a] = '0;
`endif
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (write_enb !== 1'b0 || read_enb !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_rdata !== '0 || address !== '0 || data_in !== '0) begin
      n_fail++;
      $display("FAIL reset_state got we=%b re=%b vld=%b rdata=%h addr=%h din=%h exp all 0",
               write_enb, read_enb, bus.rsp_valid, bus.rsp_rdata, address, data_in);
    end
    release_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    n_tests++;
    if (obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", obs_ready, obs_busy);
    end
    drive(1'b1, 1'b0, 4'd9, '0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    n_tests++;
    if (obs_re !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_read got re=%b exp 1", obs_re);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (write_enb !== 1'b0 || read_enb !== 1'b0 || bus.rsp_valid !== 1'b0 || address !== '0) begin
      n_fail++;
      $display("FAIL reset_async got we=%b re=%b vld=%b addr=%h exp 0 0 0 0",
               write_enb, read_enb, bus.rsp_valid, address);
    end
    release_reset();
  endtask

  task automatic test_write_read;
    int lat = -1;
    drive(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    n_tests++;
    if (hs !== 1'b1 || obs_we !== 1'b1 || obs_re !== 1'b0 || obs_addr !== 4'd3 || obs_din !== 8'hA5) begin
      n_fail++;
      $display("FAIL wr_pins got hs=%b we=%b re=%b addr=%h din=%h exp 1 1 0 3 a5",
               hs, obs_we, obs_re, obs_addr, obs_din);
    end
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      if (k == 1) begin
        n_tests++;
        if (obs_re !== 1'b1 || obs_we !== 1'b0 || obs_addr !== 4'd3 || obs_din !== 8'hA5) begin
          n_fail++;
          $display("FAIL rd_pins got re=%b we=%b addr=%h din=%h exp 1 0 3 a5", obs_re, obs_we, obs_addr, obs_din);
        end
      end
      n_tests++;
      if (obs_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL wr_rd_valid k=%0d got %b exp %b", k, obs_valid, exp_valid);
      end
      if (obs_valid === 1'b1 && lat < 0) begin
        lat = k - 1;
        n_tests++;
        if (obs_rdata !== 8'hA5) begin
          n_fail++;
          $display("FAIL wr_rd_data got %h exp a5", obs_rdata);
        end
      end
    end
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL wr_rd_latency got %0d exp 2", lat);
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] want [3] = '{8'h11, 8'h22, 8'h33};
    int acc = 0;
    int got = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, AW'(i), want[i], 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, AW'(acc), '0, 1'b0);
      if (hs) acc++;
    end
    n_tests++;
    if (acc != 2 || obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall got accepted=%0d ready=%b exp 2 0", acc, obs_ready);
    end
    for (int k = 0; k < 30 && got < 3; k++) begin
      drive(acc < 3, 1'b0, AW'(acc), '0, 1'b1);
      if (hs && acc < 3) acc++;
      n_tests++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL bp_flow got ready=%b valid=%b exp %b %b", obs_ready, obs_valid, exp_ready, exp_valid);
      end
      if (obs_valid === 1'b1) begin
        n_tests++;
        if (obs_rdata !== want[got]) begin
          n_fail++;
          $display("FAIL bp_data n=%0d got %h exp %h", got, obs_rdata, want[got]);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL bp_count got %0d exp 3", got);
    end
  endtask

  task automatic test_streaming;
    int i = 0;
    int got = 0;
    int stalls = 0;
    for (int k = 0; k < 16; k++) drive(1'b1, 1'b1, AW'(k), DW'(k * 3), 1'b1);
    for (int k = 0; k < 200 && got < 16; k++) begin
      drive(i < 16, 1'b0, AW'(i), '0, 1'b1);
      if (i < 16 && !hs) stalls++;
      if (hs && i < 16) i++;
      n_tests++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL stream_ready idx=%0d got %b exp %b", idx, obs_ready, exp_ready);
      end
      if (obs_valid === 1'b1) begin
        n_tests++;
        if (obs_rdata !== DW'(got * 3)) begin
          n_fail++;
          $display("FAIL stream_data n=%0d got %h exp %h", got, obs_rdata, DW'(got * 3));
        end
        got++;
      end
    end
    n_tests++;
    if (got != 16 || stalls == 0) begin
      n_fail++;
      $display("FAIL stream_done got responses=%0d stalls=%0d exp 16 and >0", got, stalls);
    end
  endtask

  task automatic test_random;
    req_t r;
    logic rr;
    for (int k = 0; k < 300; k++) begin
      r.write = 1'($urandom_range(0, 1));
      r.addr  = AW'($urandom);
      r.wdata = DW'($urandom);
      rr      = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), r.write, r.addr, r.wdata, rr);
      n_tests++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rdata !== exp_rdata) ||
          (obs_we && obs_re)) begin
        n_fail++;
        $display("FAIL rand idx=%0d got ready=%b valid=%b rdata=%h we=%b re=%b exp %b %b %h",
                 idx, obs_ready, obs_valid, obs_rdata, obs_we, obs_re, exp_ready, exp_valid, exp_rdata);
      end
    end
    for (int k = 0; k < 20 && pend.size() != 0; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs_valid !== exp_valid || (exp_valid && obs_rdata !== exp_rdata)) begin
        n_fail++;
        $display("FAIL rand_drain got valid=%b rdata=%h exp %b %h", obs_valid, obs_rdata, exp_valid, exp_rdata);
      end
    end
    n_tests++;
    if (pend.size() != 0) begin
      n_fail++;
      $display("FAIL rand_timeout outstanding got %0d exp 0", pend.size());
    end
  endtask

  task automatic test_reset_midop;
    int acc = 0;
    drive(1'b1, 1'b0, 4'd3, '0, 1'b1);
    if (hs) acc++;
    drive(1'b1, 1'b0, 4'd5, '0, 1'b1);
    if (hs) acc++;
    n_tests++;
    if (acc != 2) begin
      n_fail++;
      $display("FAIL midrst_accept got %0d exp 2", acc);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    release_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet k=%0d got valid=%b ready=%b busy=%b exp 0 1 0", k, obs_valid, obs_ready, obs_busy);
      end
    end
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, AW'(k), '0, 1'b0);
      if (hs) acc++;
    end
    n_tests++;
    if (acc != 2) begin
      n_fail++;
      $display("FAIL midrst_credits got accepted=%0d exp 2", acc);
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs_valid !== exp_valid || (exp_valid && obs_rdata !== exp_rdata)) begin
        n_fail++;
        $display("FAIL midrst_drain got valid=%b rdata=%h exp %b %h", obs_valid, obs_rdata, exp_valid, exp_rdata);
      end
    end
  endtask

`ifdef RAM_INIT_CLEAR_EN
  task automatic test_init_clear;
    drive(1'b1, 1'b1, 4'd7, 8'hFF, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    release_reset();
    drive(1'b1, 1'b0, 4'd7, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      if (obs_valid === 1'b1) begin
        n_tests++;
        if (obs_rdata !== 8'h00) begin
          n_fail++;
          $display("FAIL init_read got %h exp 00", obs_rdata);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
      ram[a]     = '0;
      ref_mem[a] = '0;
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_midop();
`ifdef RAM_INIT_CLEAR_EN
    test_init_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
